// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer: buffers operand pairs and sequences them through a repeated-addition multiplier engine
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready       push of operand pair (in_a, in_b) into the FIFO
//   mul_start                one-cycle start pulse to the engine
//   mul_data                 shared operand bus: A in START/LOAD_A, B in LOAD_B/WAIT, 0 otherwise
//   mul_done, mul_product    engine completion level and its result
//   res_valid, res_ready     result handshake carrying res_data and res_timeout
//   fifo_count, busy         FIFO occupancy and non-idle status
module mul_operand_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_data,
  input  logic                   mul_done,
  input  logic [WIDTH-1:0]       mul_product,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic                   res_timeout,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, START, LOAD_A, LOAD_B, WAIT, RESULT} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tcnt;
  logic push, pop, tmo_hit;
  always_comb begin
    in_ready = fifo_count < FULL;
    push = in_valid && in_ready;
    tmo_hit = tcnt == TLAST;
    pop = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (fifo_count != '0) ? START : IDLE;
      START:   state_nxt = LOAD_A;
      LOAD_A:  state_nxt = LOAD_B;
      LOAD_B:  state_nxt = WAIT;
      WAIT: begin
        pop = mul_done || tmo_hit;
        state_nxt = pop ? RESULT : WAIT;
      end
      RESULT:  state_nxt = res_ready ? IDLE : RESULT;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    mul_start = state == START;
    busy = state != IDLE;
    res_valid = state == RESULT;
    mul_data = (state == START || state == LOAD_A) ? mem_a[rd_ptr] :
               (state == LOAD_B || state == WAIT) ? mem_b[rd_ptr] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      tcnt <= '0;
      res_data <= '0;
      res_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) fifo_count <= push ? fifo_count + 1'b1 : fifo_count - 1'b1;
      if (state == LOAD_B) tcnt <= '0;
      else if (state == WAIT && !pop) tcnt <= tcnt + 1'b1;
      // done takes priority over an expiring timeout in the same cycle
      if (pop) begin
        res_data <= mul_done ? mul_product : '0;
        res_timeout <= !mul_done;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end
endmodule
